// File: rtl/monostable_clk_gen_pkg.sv
// ---------------------------------------------------------------------------
// monostable_clk_pkg
//
// Purpose:
//   Shared constants and helpers for the single-shot step clock generator
//   (monostable_clk_gen) and its push-button debouncer (push_debouncer).
//
// Contents:
//   MONO_PULSE_CYCLES_DEF    - default output pulse width in sys_clk cycles
//   MONO_DEBOUNCE_CYCLES_DEF - default number of stable cycles needed to
//                              accept a new button level
//   monoCntWidth()           - bit width needed for a counter that must hold
//                              values 0..maxValue
//
// Build option:
//   MONOSTABLE_CLK_DEBOUNCE_EN - when defined, push_debouncer contains the
//                                debounce counter; when undefined the
//                                synchronized button level is used directly.
// ---------------------------------------------------------------------------
package monostable_clk_pkg;

  localparam int MONO_PULSE_CYCLES_DEF    = 4;
  localparam int MONO_DEBOUNCE_CYCLES_DEF = 4;

  // Returns the number of bits needed to represent 0..maxValue.
  // A zero or negative range still yields a 1-bit counter so that
  // degenerate parameter values never produce a zero-width vector.
  function automatic int monoCntWidth(input int maxValue);
    if (maxValue < 1) begin
      return 1;
    end
    return $clog2(maxValue + 1);
  endfunction

endpackage : monostable_clk_pkg

// File: rtl/monostable_clk_gen_if.sv
// ---------------------------------------------------------------------------
// monostable_clk_gen_if
//
// Purpose:
//   Bundles the front-panel step button and the generated step clock into
//   one connection between the panel side and the clock generator. The
//   system clock and reset are deliberately kept outside the interface and
//   travel as plain ports.
//
// Signals:
//   push - raw step button level, active high, asynchronous, may bounce
//   clk  - single clean step pulse, active high, driven from a flop
//
// Modports:
//   master - front panel / testbench side: drives push, observes clk
//   slave  - clock generator side: observes push, drives clk
// ---------------------------------------------------------------------------
interface monostable_clk_gen_if;

  logic push;
  logic clk;

  modport master (
    output push,
    input  clk
  );

  modport slave (
    input  push,
    output clk
  );

endinterface : monostable_clk_gen_if

// File: rtl/monostable_clk_gen_debouncer.sv
// ---------------------------------------------------------------------------
// push_debouncer
//
// Purpose:
//   Brings the raw, bouncing step button into the sys_clk domain and turns
//   it into a clean level (db_level) that only changes after the new level
//   has been stable for DEBOUNCE_CYCLES consecutive cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES - stable cycles required before db_level follows the
//                     synchronized button (>= 1). Only meaningful when the
//                     debounce stage is built.
//
// Ports:
//   sys_clk  (in)  - system clock, all state on its rising edge
//   rst_n    (in)  - asynchronous active-low reset
//   push     (in)  - raw button level, asynchronous, active high
//   db_level (out) - debounced (or merely synchronized) button level
//
// Build option:
//   MONOSTABLE_CLK_DEBOUNCE_EN defined   -> counter-based debounce present,
//                                           db_level changes DEBOUNCE_CYCLES
//                                           edges after push_sync changes.
//   MONOSTABLE_CLK_DEBOUNCE_EN undefined -> db_level is push_sync directly.
// ---------------------------------------------------------------------------
module push_debouncer
  import monostable_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = MONO_DEBOUNCE_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic push,
  output logic db_level
);

  logic r_pushCapture;
  logic r_syncMeta;
  logic r_syncOut;
  logic w_pushSync;

  // The pad level is captured on the edge that first sees it (edge 0) and
  // then passes through a two-flop synchronizer, so the synchronized level
  // becomes visible after edge 2. The capture flop may go metastable, which
  // is why its output is never used for anything but the next stage.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pushCapture <= 1'b0;
      r_syncMeta    <= 1'b0;
      r_syncOut     <= 1'b0;
    end else begin
      r_pushCapture <= push;
      r_syncMeta    <= r_pushCapture;
      r_syncOut     <= r_syncMeta;
    end
  end

  assign w_pushSync = r_syncOut;

`ifdef MONOSTABLE_CLK_DEBOUNCE_EN

  // Counter only needs to reach DEBOUNCE_CYCLES-1; the transfer happens on
  // the edge where it sits at that value and the levels still disagree.
  localparam int            DB_CNT_W    = monoCntWidth(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_CNT_W-1:0] DB_CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_CNT_W-1:0] r_dbCount;
  logic                r_dbLevel;

  // Debounce: any cycle where the synchronized button agrees with the
  // accepted level restarts the count, so only an uninterrupted run of
  // DEBOUNCE_CYCLES disagreeing samples moves db_level. With
  // DEBOUNCE_CYCLES = 1 the last value is 0 and a single disagreeing
  // sample is accepted on the following edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbCount <= '0;
      r_dbLevel <= 1'b0;
    end else if (w_pushSync == r_dbLevel) begin
      r_dbCount <= '0;
    end else if (r_dbCount == DB_CNT_LAST) begin
      r_dbLevel <= w_pushSync;
      r_dbCount <= '0;
    end else begin
      r_dbCount <= r_dbCount + 1'b1;
    end
  end

  assign db_level = r_dbLevel;

`else

  // No debounce stage: every clean transition of the synchronized button
  // is passed straight through to the edge detector.
  assign db_level = w_pushSync;

`endif

endmodule : push_debouncer

// File: rtl/monostable_clk_gen.sv
// ---------------------------------------------------------------------------
// monostable_clk_gen
//
// Purpose:
//   Manual-step clock source for the 8-bit computer: the synchronous
//   equivalent of a 555 monostable. Each accepted press of the front-panel
//   step button produces exactly one clean high pulse of PULSE_CYCLES
//   sys_clk cycles on clk, regardless of bounce or how long the button is
//   held. The output feeds the clock-select mux in front of the CPU.
//
// Parameters:
//   PULSE_CYCLES    - output pulse width in sys_clk cycles (>= 1)
//   DEBOUNCE_CYCLES - stable cycles required to accept a new button level
//                     (>= 1); ignored when the debounce stage is not built
//
// Ports:
//   sys_clk (in)       - system clock, all state on its rising edge
//   rst_n   (in)       - asynchronous active-low reset; aborts any pulse
//   mono    (slave)    - monostable_clk_gen_if:
//                          mono.push (in)  raw step button
//                          mono.clk  (out) registered step pulse
//
// Build option:
//   MONOSTABLE_CLK_DEBOUNCE_EN - passed down to push_debouncer. Defined:
//   press-to-pulse latency is DEBOUNCE_CYCLES+3 edges. Undefined: 3 edges.
// ---------------------------------------------------------------------------
module monostable_clk_gen
  import monostable_clk_pkg::*;
#(
  parameter int PULSE_CYCLES    = MONO_PULSE_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES = MONO_DEBOUNCE_CYCLES_DEF
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  monostable_clk_gen_if.slave  mono
);

  localparam int               PULSE_CNT_W = monoCntWidth(PULSE_CYCLES);
  localparam logic [PULSE_CNT_W-1:0] PULSE_LOAD  = PULSE_CNT_W'(PULSE_CYCLES);
  localparam logic [PULSE_CNT_W-1:0] PULSE_LAST  = PULSE_CNT_W'(1);

  logic                   w_dbLevel;
  logic                   r_dbPrev;
  logic                   w_dbRise;
  logic [PULSE_CNT_W-1:0] r_pulseCount;
  logic                   r_clkOut;

  push_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pushDebouncer (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .push     (mono.push),
    .db_level (w_dbLevel)
  );

  // Edge detect: remember last cycle's debounced level so a press is seen
  // as a single-cycle rise. Holding the button keeps db_level high and
  // therefore produces no further rises until it has been released.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbPrev <= 1'b0;
    end else begin
      r_dbPrev <= w_dbLevel;
    end
  end

  assign w_dbRise = w_dbLevel & ~r_dbPrev;

  // Pulse generator: a rise seen while idle loads the width and raises
  // clk on the same edge. While the pulse runs the counter only counts
  // down, so rises arriving mid-pulse are dropped rather than queued.
  // clk is cleared on the edge that takes the counter from 1 to 0, which
  // keeps it high for exactly PULSE_CYCLES edges. clk comes straight from
  // a flop so the CPU never sees a combinational glitch.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulseCount <= '0;
      r_clkOut     <= 1'b0;
    end else if (r_clkOut) begin
      r_pulseCount <= r_pulseCount - 1'b1;
      if (r_pulseCount == PULSE_LAST) begin
        r_clkOut <= 1'b0;
      end
    end else if (w_dbRise) begin
      r_pulseCount <= PULSE_LOAD;
      r_clkOut     <= 1'b1;
    end
  end

  assign mono.clk = r_clkOut;

endmodule : monostable_clk_gen

// File: tb/tb_monostable_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_monostable_clk_gen
//
// Directed stimulus for monostable_clk_gen with a pulse scoreboard. Each
// stimulus step that should cause a pulse pushes {start edge, width} into
// a queue; a monitor watches clk on falling sys_clk edges, measures every
// pulse it sees and checks it against the head of the queue. Expected
// start edges are derived from the edge that first samples the press
// (edge 0) plus the press-to-pulse latency of the selected build.
// ---------------------------------------------------------------------------
module tb_monostable_clk_gen;
  import monostable_clk_pkg::*;

  localparam int P = MONO_PULSE_CYCLES_DEF;
  localparam int D = MONO_DEBOUNCE_CYCLES_DEF;
`ifdef MONOSTABLE_CLK_DEBOUNCE_EN
  localparam int LAT = D + 3;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    int start;
    int width;
  } pulse_t;

  logic   sys_clk = 1'b0;
  logic   rst_n   = 1'b1;
  int     cyc     = 0;
  int     total   = 0;
  int     bad     = 0;
  pulse_t expQ[$];

  monostable_clk_gen_if mono ();

  monostable_clk_gen #(
    .PULSE_CYCLES    (P),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .mono    (mono)
  );

  // Free-running clock and an edge counter used to timestamp pulses.
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
  end

  task automatic expectPulse(input int start, input int width);
    pulse_t e;
    e.start = start;
    e.width = width;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic got, input logic req);
    total++;
    if (got !== req) begin
      bad++;
      $display("[TB] FAIL %s: clk=%b required %b at edge %0d", name, got, req, cyc);
    end
  endtask

  task automatic checkPulse(input int gotStart, input int gotWidth);
    pulse_t e;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL pulse: got start=%0d width=%0d, required no pulse", gotStart, gotWidth);
    end else begin
      e = expQ.pop_front();
      if (e.start != gotStart || e.width != gotWidth) begin
        bad++;
        $display("[TB] FAIL pulse: got start=%0d width=%0d, required start=%0d width=%0d",
                 gotStart, gotWidth, e.start, e.width);
      end
    end
  endtask

  // Monitor: samples clk on falling edges, so a pulse raised by edge k is
  // first seen with cyc == k and its width is the number of high samples.
  task automatic monitorPulses();
    logic prevClk  = 1'b0;
    int   startCyc = 0;
    int   width    = 0;
    forever begin
      @(negedge sys_clk);
      if (mono.clk === 1'b1) begin
        if (!prevClk) begin
          startCyc = cyc;
          width    = 0;
        end
        width++;
        prevClk = 1'b1;
      end else begin
        if (prevClk) begin
          checkPulse(startCyc, width);
        end
        prevClk = 1'b0;
      end
    end
  endtask

  // Drives push for `cycles` sampling edges. Called 2 time units after a
  // rising edge; returns at the same phase after the last sampling edge.
  task automatic applyStimulus(input logic value, input int cycles);
    mono.push = value;
    repeat (cycles) @(posedge sys_clk);
    #2;
  endtask

  initial begin
    int e0;
    int s;
    mono.push = 1'b0;
    fork
      monitorPulses();
    join_none
    #1 rst_n = 1'b0;
    @(posedge sys_clk);
    #2;

    // Reset held for 3 cycles, then 20 idle cycles with push low.
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checkOutput("clkInReset", mono.clk, 1'b0);
      @(posedge sys_clk);
      #2;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      checkOutput("clkIdleAfterReset", mono.clk, 1'b0);
      @(posedge sys_clk);
      #2;
    end

    // Single press of 10 cycles.
    e0 = cyc + 1;
    expectPulse(e0 + LAT, P);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 20);

    // Held press of 50 cycles, then a second press after 10 low cycles.
    e0 = cyc + 1;
    expectPulse(e0 + LAT, P);
    applyStimulus(1'b1, 50);
    applyStimulus(1'b0, 10);
    e0 = cyc + 1;
    expectPulse(e0 + LAT, P);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 20);

    // Bounce: 8 single-cycle toggles starting high, then stable high.
    e0 = cyc + 1;
`ifndef MONOSTABLE_CLK_DEBOUNCE_EN
    expectPulse(e0 + 3, P);
    expectPulse(e0 + 9, P);
`endif
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i % 2 == 0) ? 1'b1 : 1'b0, 1);
    end
    e0 = cyc + 1;
`ifdef MONOSTABLE_CLK_DEBOUNCE_EN
    expectPulse(e0 + LAT, P);
`endif
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 20);

    // Short presses: 2 cycles and D-1 cycles are glitches when debounced.
    e0 = cyc + 1;
`ifndef MONOSTABLE_CLK_DEBOUNCE_EN
    expectPulse(e0 + 3, P);
`endif
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 20);
    e0 = cyc + 1;
`ifndef MONOSTABLE_CLK_DEBOUNCE_EN
    expectPulse(e0 + 3, P);
`endif
    applyStimulus(1'b1, D - 1);
    applyStimulus(1'b0, 20);

    // Press of exactly D cycles is the shortest accepted press.
    e0 = cyc + 1;
    expectPulse(e0 + LAT, P);
    applyStimulus(1'b1, D);
    applyStimulus(1'b0, 20);

    // Low glitch of D-1 cycles while held must not retrigger when debounced.
    e0 = cyc + 1;
    expectPulse(e0 + LAT, P);
    applyStimulus(1'b1, 20);
    e0 = cyc + 1;
`ifndef MONOSTABLE_CLK_DEBOUNCE_EN
    expectPulse(e0 + (D - 1) + 3, P);
`endif
    applyStimulus(1'b0, D - 1);
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 20);

    // Reset during pulse cycle 2 with push still high: aborted 1-sample
    // pulse, then one full pulse LAT edges after release.
    e0 = cyc + 1;
    s  = e0 + LAT;
    expectPulse(s, 1);
    applyStimulus(1'b1, LAT + 2);
    rst_n = 1'b0;
    #1;
    checkOutput("clkAbortedByReset", mono.clk, 1'b0);
    @(posedge sys_clk);
    #2;
    @(posedge sys_clk);
    #2;
    rst_n = 1'b1;
    e0 = cyc + 1;
    expectPulse(e0 + LAT, P);
    applyStimulus(1'b1, LAT + P + 5);
    applyStimulus(1'b0, 30);

    // Every expected pulse must have been observed.
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL pendingPulses: got %0d unobserved, required 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_monostable_clk_gen
